// File: rtl/trellis_lut.sv
// trellis_lut: captures one decode-mode sweep of the convolutional encoder
// into a transition table, then serves registered reads to the radix-4
// branch metric stage.
//
// Optional feature macro: TRELLIS_LUT_PARITY_EN
//   defined   -> each entry carries a parity bit, o_par_err port added
//   undefined -> plain 6-bit entries, no parity logic
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_start         pulse: request a table (re)fill
//   i_mux           encoder scan word {pair, state, second, first}
//   o_en_ce         encoder enable, high during FILL
//   o_mode_sel      encoder mode, DECODE during FILL, ENCODE otherwise
//   i_rd_en         read request (honoured in READY only)
//   i_rd_addr       read address {state, pair}
//   o_rd_data       {second, first} of the addressed transition
//   o_rd_valid      o_rd_data valid (1-cycle read latency)
//   o_busy          fill in progress
//   o_ready         table complete and valid
//   o_done          one-cycle pulse on fill completion
//   o_err           sticky scan index mismatch
//   o_par_err       (parity build) stored parity mismatch on read

`ifndef ENCODE_MODE
`define ENCODE_MODE 1'b0
`endif
`ifndef DECODE_MODE
`define DECODE_MODE 1'b1
`endif

module trellis_lut #(
   parameter int unsigned MAX_STATE_REG_NUM = 8,
   parameter int unsigned DECODE_BIT_NUM    = 2,
   parameter int unsigned MAX_CODE_RATE     = 3,
   parameter int unsigned LUT_DEPTH         = 1024
) (
   input  logic                                                       clk,
   input  logic                                                       rst,
   input  logic                                                       i_start,
   input  logic [DECODE_BIT_NUM+MAX_STATE_REG_NUM+2*MAX_CODE_RATE-1:0] i_mux,
   output logic                                                       o_en_ce,
   output logic                                                       o_mode_sel,
   input  logic                                                       i_rd_en,
   input  logic [MAX_STATE_REG_NUM+DECODE_BIT_NUM-1:0]                i_rd_addr,
   output logic [2*MAX_CODE_RATE-1:0]                                 o_rd_data,
   output logic                                                       o_rd_valid,
`ifdef TRELLIS_LUT_PARITY_EN
   output logic                                                       o_par_err,
`endif
   output logic                                                       o_busy,
   output logic                                                       o_ready,
   output logic                                                       o_done,
   output logic                                                       o_err
);

   localparam int unsigned ADDR_W = MAX_STATE_REG_NUM + DECODE_BIT_NUM;
   localparam int unsigned DATA_W = 2 * MAX_CODE_RATE;
   localparam int unsigned MUX_W  = ADDR_W + DATA_W;
`ifdef TRELLIS_LUT_PARITY_EN
   localparam int unsigned ENTRY_W = DATA_W + 1;
`else
   localparam int unsigned ENTRY_W = DATA_W;
`endif
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LUT_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, FILL, READY} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
   logic                err_q, err_d;
   logic                done_q, done_d;
   logic                rd_valid_q;
   logic [DATA_W-1:0]   rd_data_q;
   logic [ENTRY_W-1:0]  mem [LUT_DEPTH];
   logic [ENTRY_W-1:0]  wr_word_c;
   logic [ENTRY_W-1:0]  rd_word_c;
   logic                idx_mismatch_c;
   logic                rd_fire_c;

   // Scan word must carry the same {state, pair} as the address being written
   assign idx_mismatch_c =
      (i_mux[MUX_W-1 -: DECODE_BIT_NUM] != wr_cnt_q[DECODE_BIT_NUM-1:0]) ||
      (i_mux[DATA_W +: MAX_STATE_REG_NUM] != wr_cnt_q[ADDR_W-1 -: MAX_STATE_REG_NUM]);

`ifdef TRELLIS_LUT_PARITY_EN
   assign wr_word_c = {^i_mux[DATA_W-1:0], i_mux[DATA_W-1:0]};
`else
   assign wr_word_c = i_mux[DATA_W-1:0];
`endif

   assign rd_fire_c = i_rd_en && (state_q == READY);
   assign rd_word_c = mem[i_rd_addr];

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         wr_cnt_q <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         err_q    <= err_d;
         done_q   <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      err_d    = err_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d  = FILL;
               wr_cnt_d = '0;
            end
         end
         FILL: begin
            // counter wraps to 0 after the last entry, matching the encoder
            wr_cnt_d = ADDR_W'(wr_cnt_q + 1'b1);
            if (idx_mismatch_c) err_d = 1'b1;
            if (wr_cnt_q == LAST_IDX) begin
               state_d = READY;
               done_d  = 1'b1;
            end
         end
         READY: begin
            if (i_start) begin
               state_d  = FILL;
               wr_cnt_d = '0;
               err_d    = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Table write port: contents intentionally survive reset
   always_ff @(posedge clk) begin
      if (state_q == FILL) mem[wr_cnt_q] <= wr_word_c;
   end

   // Registered read port; data holds when no read is accepted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_fire_c;
         if (rd_fire_c) rd_data_q <= rd_word_c[DATA_W-1:0];
      end
   end

`ifdef TRELLIS_LUT_PARITY_EN
   logic par_err_q;

   // Stored parity bit makes the whole entry even-parity when intact
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) par_err_q <= 1'b0;
      else      par_err_q <= rd_fire_c && (^rd_word_c);
   end

   assign o_par_err = par_err_q;
`endif

   assign o_en_ce    = (state_q == FILL);
   assign o_mode_sel = (state_q == FILL) ? `DECODE_MODE : `ENCODE_MODE;
   assign o_busy     = (state_q == FILL);
   assign o_ready    = (state_q == READY);
   assign o_done     = done_q;
   assign o_err      = err_q;
   assign o_rd_data  = rd_data_q;
   assign o_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_trellis_lut.sv
// tb_trellis_lut: bench for trellis_lut with a behavioural encoder
// (gen_poly {9'o7, 9'o5, 0}) feeding the decode-mode scan.
`timescale 1ns/1ps

`ifndef ENCODE_MODE
`define ENCODE_MODE 1'b0
`endif
`ifndef DECODE_MODE
`define DECODE_MODE 1'b1
`endif

module tb_trellis_lut;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_start = 1'b0;
   logic [15:0] i_mux;
   logic        i_rd_en = 1'b0;
   logic [9:0]  i_rd_addr = '0;
   logic        o_en_ce, o_mode_sel, o_rd_valid, o_busy, o_ready, o_done, o_err;
   logic [5:0]  o_rd_data;
`ifdef TRELLIS_LUT_PARITY_EN
   logic        o_par_err;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   trellis_lut dut (
      .clk        (clk),
      .rst        (rst),
      .i_start    (i_start),
      .i_mux      (i_mux),
      .o_en_ce    (o_en_ce),
      .o_mode_sel (o_mode_sel),
      .i_rd_en    (i_rd_en),
      .i_rd_addr  (i_rd_addr),
      .o_rd_data  (o_rd_data),
      .o_rd_valid (o_rd_valid),
`ifdef TRELLIS_LUT_PARITY_EN
      .o_par_err  (o_par_err),
`endif
      .o_busy     (o_busy),
      .o_ready    (o_ready),
      .o_done     (o_done),
      .o_err      (o_err)
   );

   // Reference: two encoder steps from `state`, first input pair[0], then pair[1]
   function automatic logic [5:0] golden(input logic [9:0] a);
      logic [8:0] poly [3];
      logic [7:0] st;
      logic [8:0] r;
      logic [2:0] o1, o2;
      poly = '{9'o7, 9'o5, 9'o0};
      st = a[9:2];
      r  = {st, a[0]};
      for (int k = 0; k < 3; k++) o1[k] = ^(r & poly[k]);
      st = r[7:0];
      r  = {st, a[1]};
      for (int k = 0; k < 3; k++) o2[k] = ^(r & poly[k]);
      return {o2, o1};
   endfunction

   // Behavioural encoder scan: advances while enabled, wraps every 1024
   int         enc_cnt;
   int         bad_at = -1;
   logic [9:0] enc_a;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         enc_cnt <= 0;
      else if (o_en_ce) enc_cnt <= (enc_cnt + 1) % 1024;
   end

   always_comb begin
      enc_a = 10'(enc_cnt);
      i_mux = {enc_a[1:0], enc_a[9:2], golden(enc_a)};
      if (enc_cnt == bad_at) i_mux[13:6] = ~enc_a[9:2];
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full fill from a start pulse; optional stray starts and index fault
   task automatic run_fill(input bit extra, input int inj);
      int n, d, enbad;
      logic [5:0] hold;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      check("err_clear_on_start", o_err, 0);
      check("busy_after_start", o_busy, 1);
      hold    = o_rd_data;
      i_rd_en = 1'b1;
      i_rd_addr = 10'h155;
      n = 0; d = 0; enbad = 0;
      while (o_busy && n < 2000) begin
         if (!o_en_ce || o_mode_sel !== `DECODE_MODE) enbad++;
         if (o_done) d++;
         if (o_rd_valid || o_rd_data !== hold) enbad++;
         if (inj >= 0 && n == inj)     check("err_before_fault", o_err, 0);
         if (inj >= 0 && n == inj + 1) check("err_after_fault", o_err, 1);
         i_start = extra && (n == 100 || n == 600);
         n++;
         tick();
      end
      i_start = 1'b0;
      i_rd_en = 1'b0;
      check("fill_cycles", n, 1024);
      check("done_pulse", o_done, 1);
      check("done_early", d, 0);
      check("fill_en_mode_read", enbad, 0);
      check("ready_after_fill", o_ready, 1);
      check("en_ce_after_fill", o_en_ce, 0);
      check("mode_after_fill", o_mode_sel, `ENCODE_MODE);
      check("valid_after_fill", o_rd_valid, 0);
      tick();
      check("done_single", o_done, 0);
   endtask

   typedef struct {
      logic       rd_en;
      logic [9:0] addr;
      logic       exp_v;
      logic [5:0] exp_d;
   } vec_t;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t       vecs [7];
      logic       en;
      logic [9:0] a;
      logic [5:0] exp_d;

      // Reset and idle with a read requested outside READY
      tick(); tick();
      rst = 1'b1;
      i_rd_en = 1'b1;
      repeat (5) tick();
      check("idle_en_ce", o_en_ce, 0);
      check("idle_mode", o_mode_sel, `ENCODE_MODE);
      check("idle_busy", o_busy, 0);
      check("idle_ready", o_ready, 0);
      check("idle_valid", o_rd_valid, 0);
      check("idle_data", o_rd_data, 0);
      check("idle_done", o_done, 0);
      check("idle_err", o_err, 0);
      i_rd_en = 1'b0;
      tick();

      run_fill(1'b0, -1);
      check("fill1_err", o_err, 0);

      vecs[0] = '{1'b1, 10'h000, 1'b1, 6'b000_000};
      vecs[1] = '{1'b1, 10'h001, 1'b1, 6'b001_011};
      vecs[2] = '{1'b1, 10'h3FF, 1'b1, 6'b001_001};
      vecs[3] = '{1'b0, 10'h002, 1'b0, 6'b001_001};
      vecs[4] = '{1'b1, 10'h002, 1'b1, 6'b011_000};
      vecs[5] = '{1'b1, 10'h004, 1'b1, 6'b011_001};
      vecs[6] = '{1'b0, 10'h3FF, 1'b0, 6'b011_001};
      for (int i = 0; i < 7; i++) begin
         i_rd_en   = vecs[i].rd_en;
         i_rd_addr = vecs[i].addr;
         tick();
         check($sformatf("vec%0d_valid", i), o_rd_valid, vecs[i].exp_v);
         check($sformatf("vec%0d_data", i), o_rd_data, vecs[i].exp_d);
      end
      i_rd_en = 1'b0;

      // Back-to-back reads 1..8
      i_rd_en = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         i_rd_addr = 10'(i);
         tick();
         check($sformatf("b2b%0d_valid", i), o_rd_valid, 1);
         check($sformatf("b2b%0d_data", i), o_rd_data, golden(10'(i)));
`ifdef TRELLIS_LUT_PARITY_EN
         check($sformatf("b2b%0d_par", i), o_par_err, 0);
`endif
      end
      i_rd_en = 1'b0;
      tick();
      check("b2b_end_valid", o_rd_valid, 0);

      // Fill with stray starts and a corrupted state field on the 10th cycle
      bad_at = 9;
      run_fill(1'b1, 9);
      bad_at = -1;
      check("err_sticky_ready", o_err, 1);
      i_rd_en = 1'b1; i_rd_addr = 10'h001;
      tick();
      i_rd_en = 1'b0;
      check("err_fill_read", o_rd_data, 6'b001_011);
      repeat (3) tick();
      check("err_still_set", o_err, 1);

      // Read coinciding with start, then reset mid-fill
      i_rd_en = 1'b1; i_rd_addr = 10'h005; i_start = 1'b1;
      tick();
      i_rd_en = 1'b0; i_start = 1'b0;
      check("coinc_valid", o_rd_valid, 1);
      check("coinc_data", o_rd_data, golden(10'h005));
      check("coinc_busy", o_busy, 1);
      check("coinc_err_clear", o_err, 0);
      repeat (499) tick();
      rst = 1'b0;
      #1;
      check("rst_busy", o_busy, 0);
      check("rst_ready", o_ready, 0);
      check("rst_en_ce", o_en_ce, 0);
      check("rst_mode", o_mode_sel, `ENCODE_MODE);
      check("rst_valid", o_rd_valid, 0);
      check("rst_data", o_rd_data, 0);
      tick();
      rst = 1'b1;
      tick();
      check("post_rst_ready", o_ready, 0);
      run_fill(1'b0, -1);
      check("refill_err", o_err, 0);

      // Random reads against the reference model
      i_rd_en = 1'b1; i_rd_addr = 10'h3FF;
      tick();
      exp_d = golden(10'h3FF);
      check("rand_seed_data", o_rd_data, exp_d);
      for (int i = 0; i < 300; i++) begin
         en = ($urandom % 4) != 0;
         a  = 10'($urandom % 1024);
         i_rd_en = en; i_rd_addr = a;
         tick();
         if (en) exp_d = golden(a);
         check("rand_valid", o_rd_valid, en);
         check("rand_data", o_rd_data, exp_d);
`ifdef TRELLIS_LUT_PARITY_EN
         check("rand_par", o_par_err, 0);
`endif
      end
      i_rd_en = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
